interp_window_buffer: RTL and testbench

Parametrised sliding-window row buffer feeding the HEVC sub-pixel interpolation filters. It accepts one row of pixels per valid/ready handshake and keeps the newest DEPTH rows as a flat window, presenting a fresh window for every accepted row once full. It sits between the reference-block fetch path and the 8-tap vertical/horizontal filter arrays. It replaces fixed-size shift registers with generic pixel width, row width and depth, flow control, flush, and optional transposed output.

---
 rtl/interp_window_buffer.sv | 89 ++++++++
 tb/tb_interp_window_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/interp_window_buffer.sv
// interp_window_buffer: sliding window of the newest DEPTH pixel rows for the sub-pixel interpolation filters.
//   clock, reset_L   : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : row input handshake; pixel c at [c*PIX_W +: PIX_W]
//   flush            : synchronous clear of the window, fill count and window count
//   transpose        : column-major output select (only when WINDOW_TRANSPOSE_EN is defined)
//   out_valid/out_ready/out_window : window output handshake; row 0 is the oldest row
//   fill_cnt         : rows held, saturating at DEPTH
//   win_cnt          : windows delivered since reset or flush, wrapping
module interp_window_buffer #(
   parameter int PIX_W   = 8,
   parameter int ROW_PIX = 15,
   parameter int DEPTH   = 15,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                             clock,
   input  logic                             reset_L,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ROW_PIX*PIX_W-1:0]         in_data,
   input  logic                             flush,
`ifdef WINDOW_TRANSPOSE_EN
   input  logic                             transpose,
`endif
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DEPTH*ROW_PIX*PIX_W-1:0]   out_window,
   output logic [CNT_W-1:0]                 fill_cnt,
   output logic [15:0]                      win_cnt
);
   localparam int ROW_W = ROW_PIX * PIX_W;
   localparam int WIN_W = DEPTH * ROW_W;
   typedef enum logic [1:0] {FILL, VALID, SPENT} state_t;
   state_t state_q, state_d;
   logic [WIN_W-1:0] rows_q, rows_d;
   logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [15:0] win_cnt_q, win_cnt_d;
   logic accept, deliver;
   assign in_ready = !flush && (state_q != VALID || out_ready);
   assign out_valid = state_q == VALID;
   assign accept = in_valid && in_ready;
   assign deliver = out_valid && out_ready;
   assign fill_cnt = fill_cnt_q;
   assign win_cnt = win_cnt_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (accept && fill_cnt_q == CNT_W'(DEPTH - 1)) state_d = VALID;
         VALID:   if (out_ready) state_d = accept ? VALID : SPENT;
         SPENT:   if (accept) state_d = VALID;
         default: state_d = FILL;
      endcase
      if (flush) state_d = FILL;
      fill_cnt_d = flush ? '0 : (accept && fill_cnt_q != CNT_W'(DEPTH)) ? fill_cnt_q + CNT_W'(1) : fill_cnt_q;
      win_cnt_d = flush ? '0 : deliver ? win_cnt_q + 16'd1 : win_cnt_q;
      // newest row enters at the top; everything else moves one row toward row 0
      rows_d = flush ? '0 : accept ? (rows_q >> ROW_W) | (WIN_W'(in_data) << ((DEPTH - 1) * ROW_W)) : rows_q;
   end
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= FILL;
         rows_q <= '0;
         fill_cnt_q <= '0;
         win_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rows_q <= rows_d;
         fill_cnt_q <= fill_cnt_d;
         win_cnt_q <= win_cnt_d;
      end
   end
`ifdef WINDOW_TRANSPOSE_EN
   // storage stays row-major so it can shift; the output copy is reordered per accept
   logic [WIN_W-1:0] out_window_q, out_window_d, trans_win;
   always_comb begin
      trans_win = '0;
      for (int r = 0; r < DEPTH; r++)
         for (int c = 0; c < ROW_PIX; c++)
            trans_win[(c*DEPTH + r)*PIX_W +: PIX_W] = rows_d[(r*ROW_PIX + c)*PIX_W +: PIX_W];
      out_window_d = flush ? '0 : accept ? (transpose ? trans_win : rows_d) : out_window_q;
   end
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) out_window_q <= '0;
      else out_window_q <= out_window_d;
   end
   assign out_window = out_window_q;
`else
   assign out_window = rows_q;
`endif
endmodule

// File: tb/tb_interp_window_buffer.sv
// tb_interp_window_buffer: scoreboard bench for interp_window_buffer with default parameters.
module tb_interp_window_buffer;
   localparam int PIX_W   = 8;
   localparam int ROW_PIX = 15;
   localparam int DEPTH   = 15;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ROW_W   = ROW_PIX * PIX_W;
   localparam int W       = DEPTH * ROW_W;
   logic clock = 1'b0;
   logic reset_L = 1'b0;
   logic in_valid = 1'b0;
   logic flush = 1'b0;
   logic out_ready = 1'b0;
   logic [ROW_W-1:0] in_data = '0;
   logic in_ready, out_valid;
   logic [W-1:0] out_window;
   logic [CNT_W-1:0] fill_cnt;
   logic [15:0] win_cnt;
`ifdef WINDOW_TRANSPOSE_EN
   logic transpose = 1'b0;
`endif
   interp_window_buffer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
`ifdef WINDOW_TRANSPOSE_EN
      .transpose(transpose),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
      .fill_cnt(fill_cnt), .win_cnt(win_cnt));
   always #5 clock = ~clock;
   int total = 0;
   int bad = 0;
   logic [7:0] mpix [DEPTH][ROW_PIX];
   int mfill, mwin, mstate;
   logic [W-1:0] sb [$];
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      int idx;
      total++;
      if (got !== exp) begin
         bad++;
         idx = 0;
         for (int i = W/8 - 1; i >= 0; i--) if (got[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
         $display("FAIL %s byte%0d got=%h exp=%h", tag, idx, got[idx*8 +: 8], exp[idx*8 +: 8]);
      end
   endtask
   function automatic logic [W-1:0] mflat();
      logic [W-1:0] w;
      w = '0;
      for (int r = 0; r < DEPTH; r++)
         for (int c = 0; c < ROW_PIX; c++) w[(r*ROW_PIX + c)*8 +: 8] = mpix[r][c];
      return w;
   endfunction
   function automatic logic [ROW_W-1:0] mk_row(input int k, input int seed);
      logic [ROW_W-1:0] d;
      for (int c = 0; c < ROW_PIX; c++) d[c*8 +: 8] = 8'(k + c*seed);
      return d;
   endfunction
   task automatic mreset();
      for (int r = 0; r < DEPTH; r++)
         for (int c = 0; c < ROW_PIX; c++) mpix[r][c] = 8'd0;
      mfill = 0;
      mwin = 0;
      mstate = 0;
      sb.delete();
   endtask
   task automatic step(input bit v, input bit rdy, input bit fl, input logic [ROW_W-1:0] d);
      bit acc;
      @(negedge clock);
      in_valid = v;
      out_ready = rdy;
      flush = fl;
      in_data = d;
      #1;
      chk("in_ready", W'(in_ready), W'(!fl && (mstate != 1 || rdy)));
      chk("out_valid", W'(out_valid), W'(mstate == 1));
      if (out_valid && rdy) begin
         chk("sb_nonempty", W'(sb.size() > 0), W'(1));
         if (sb.size() > 0) chk("window", out_window, sb.pop_front());
      end
      acc = v && !fl && (mstate != 1 || rdy);
      @(posedge clock);
      if (fl) mreset();
      else begin
         if (mstate == 1 && rdy) mwin = (mwin + 1) & 16'hFFFF;
         if (acc) begin
            for (int r = 0; r < DEPTH - 1; r++) mpix[r] = mpix[r+1];
            for (int c = 0; c < ROW_PIX; c++) mpix[DEPTH-1][c] = d[c*8 +: 8];
            if (mfill < DEPTH) mfill++;
         end
         if (acc && mfill == DEPTH) begin
            mstate = 1;
            sb.push_back(mflat());
         end else if (mstate == 1 && rdy) mstate = 2;
      end
      #1;
      chk("fill_cnt", W'(fill_cnt), W'(mfill));
      chk("win_cnt", W'(win_cnt), W'(mwin));
      chk("out_window_reg", out_window, mflat());
   endtask
   initial begin
      mreset();
      #12;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_window", out_window, '0);
      chk("rst_fill_cnt", W'(fill_cnt), W'(0));
      chk("rst_win_cnt", W'(win_cnt), W'(0));
      @(negedge clock);
      reset_L = 1'b1;
      #1;
      chk("rst_in_ready", W'(in_ready), W'(1));
      for (int k = 0; k < DEPTH; k++) step(1, 0, 0, mk_row(k, 0));
      chk("fill_full", W'(fill_cnt), W'(15));
      chk("fill_row7", W'(out_window[7*ROW_W +: 8]), W'(7));
      chk("fill_row14", W'(out_window[14*ROW_W + 3*8 +: 8]), W'(14));
      repeat (5) step(1, 0, 0, mk_row(15, 0));
      step(1, 1, 0, mk_row(15, 0));
      chk("bp_win_cnt", W'(win_cnt), W'(1));
      step(0, 0, 1, '0);
      for (int k = 0; k < 40; k++) step(1, 1, 0, mk_row(k, 5));
      step(0, 1, 0, '0);
      chk("stream_win_cnt", W'(win_cnt), W'(26));
      chk("stream_last_row", W'(out_window[14*ROW_W +: 8]), W'(39));
      chk("stream_first_row", W'(out_window[0 +: 8]), W'(25));
      chk("spent_out_valid", W'(out_valid), W'(0));
      step(1, 0, 0, mk_row(40, 5));
      chk("respent_out_valid", W'(out_valid), W'(1));
      step(0, 1, 0, '0);
      step(0, 0, 1, '0);
      for (int k = 0; k < 7; k++) step(1, 0, 0, mk_row(k, 9));
      step(1, 0, 1, mk_row(99, 9));
      chk("flush_fill_cnt", W'(fill_cnt), W'(0));
      chk("flush_window", out_window, '0);
      for (int k = 0; k < DEPTH; k++) step(1, 0, 0, mk_row(k + 50, 11));
      @(negedge clock);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2 reset_L = 1'b0;
      #1;
      chk("arst_out_valid", W'(out_valid), W'(0));
      chk("arst_out_window", out_window, '0);
      chk("arst_fill_cnt", W'(fill_cnt), W'(0));
      mreset();
      #1 reset_L = 1'b1;
      for (int k = 0; k < 3; k++) step(1, 1, 0, mk_row(k + 70, 2));
`ifdef WINDOW_TRANSPOSE_EN
      step(0, 0, 1, '0);
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clock);
         in_valid = 1'b1;
         transpose = 1'b1;
         in_data = mk_row(k, 1);
      end
      @(negedge clock);
      in_valid = 1'b0;
      chk("transpose_77", W'(out_window[77*8 +: 8]), W'(7));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
